control_sequencer: RTL

- Hardwired control unit that sits directly upstream of Datapath and drives every Datapath control strobe, replacing the hand-stepped bench FSM.
- Runs the three-step fetch (T0–T2), decodes the IR contents fed back from Datapath, then runs the three-step execute (T3–T5) for register-register ALU instructions.
- Also handles halt, nop, a memory-ready stall and start/stop control.

---
 rtl/control_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the Datapath control strobes.
// Optional single-step mode under `SINGLE_STEP_EN` (adds Step input and WAIT_STEP state).
module control_sequencer #(
    parameter int OPC_W = 5,
    parameter int CTL_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [31:0]      IR,
    input  logic             Mem_Ready,
    input  logic             Start,
    input  logic             Stop,
`ifdef SINGLE_STEP_EN
    input  logic             Step,
`endif
    output logic             PC_Out,
    output logic             ZLO_Out,
    output logic             MDR_Out,
    output logic             MAR_In,
    output logic             PC_In,
    output logic             MDR_In,
    output logic             IR_In,
    output logic             Y_In,
    output logic             Z_In,
    output logic             IncPC,
    output logic             Read,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             R_In,
    output logic             R_Out,
    output logic [CTL_W-1:0] CONTROL,
    output logic             Run
);

    typedef enum logic [3:0] {
        RESET_ST  = 4'd0,
        T0        = 4'd1,
        T1        = 4'd2,
        T2        = 4'd3,
        T3        = 4'd4,
        T4        = 4'd5,
        T5        = 4'd6,
        HALT      = 4'd7
`ifdef SINGLE_STEP_EN
        ,
        WAIT_STEP = 4'd8
`endif
    } state_e;

`ifdef SINGLE_STEP_EN
    localparam state_e INSTR_DONE = WAIT_STEP;
`else
    localparam state_e INSTR_DONE = T0;
`endif

    localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(5'b01001);
    localparam logic [OPC_W-1:0] OPC_SUB  = OPC_W'(5'b01010);
    localparam logic [OPC_W-1:0] OPC_AND  = OPC_W'(5'b01011);
    localparam logic [OPC_W-1:0] OPC_OR   = OPC_W'(5'b01100);
    localparam logic [OPC_W-1:0] OPC_SHR  = OPC_W'(5'b01101);
    localparam logic [OPC_W-1:0] OPC_SHL  = OPC_W'(5'b01110);
    localparam logic [OPC_W-1:0] OPC_HALT = OPC_W'(5'b11011);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   opc_q, opc_d;
    logic [OPC_W-1:0]   ir_opc;
    logic               unused_ir;

    assign ir_opc    = IR[31 -: OPC_W];
    assign unused_ir = ^IR[31-OPC_W:0];

    function automatic logic is_alu(input logic [OPC_W-1:0] op);
        return op inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR, OPC_SHL};
    endfunction

    function automatic logic [CTL_W-1:0] alu_ctl(input logic [OPC_W-1:0] op);
        logic [CTL_W-1:0] ctl;
        case (op)
            OPC_ADD: ctl = CTL_W'(0);
            OPC_SUB: ctl = CTL_W'(1);
            OPC_AND: ctl = CTL_W'(2);
            OPC_OR:  ctl = CTL_W'(3);
            OPC_SHR: ctl = CTL_W'(4);
            OPC_SHL: ctl = CTL_W'(5);
            default: ctl = '0;
        endcase
        return ctl;
    endfunction

    // Opcode is a data register: loaded in T3, consumed in T4, no reset needed.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= RESET_ST;
        end else begin
            state_q <= state_d;
        end
        opc_q <= opc_d;
    end

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        PC_Out  = 1'b0;
        ZLO_Out = 1'b0;
        MDR_Out = 1'b0;
        MAR_In  = 1'b0;
        PC_In   = 1'b0;
        MDR_In  = 1'b0;
        IR_In   = 1'b0;
        Y_In    = 1'b0;
        Z_In    = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        R_In    = 1'b0;
        R_Out   = 1'b0;
        CONTROL = '0;
        Run     = (state_q != HALT) && (state_q != RESET_ST);

        case (state_q)
            RESET_ST: state_d = T0;
            T0: begin
                PC_Out  = 1'b1;
                MAR_In  = 1'b1;
                IncPC   = 1'b1;
                Z_In    = 1'b1;
                state_d = Stop ? HALT : T1;
            end
            // Reloading PC from an unchanged Z makes holding T1 during a stall harmless.
            T1: begin
                ZLO_Out = 1'b1;
                PC_In   = 1'b1;
                Read    = 1'b1;
                MDR_In  = 1'b1;
                if (Mem_Ready) state_d = T2;
            end
            T2: begin
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
                state_d = T3;
            end
            T3: begin
                opc_d = ir_opc;
                if (is_alu(ir_opc)) begin
                    Grb     = 1'b1;
                    R_Out   = 1'b1;
                    Y_In    = 1'b1;
                    state_d = T4;
                end else if (ir_opc == OPC_HALT) begin
                    state_d = HALT;
                end else begin
                    state_d = INSTR_DONE;
                end
            end
            T4: begin
                Grc     = 1'b1;
                R_Out   = 1'b1;
                Z_In    = 1'b1;
                CONTROL = alu_ctl(opc_q);
                state_d = T5;
            end
            T5: begin
                ZLO_Out = 1'b1;
                Gra     = 1'b1;
                R_In    = 1'b1;
                state_d = INSTR_DONE;
            end
            HALT: begin
                if (Start) state_d = T0;
            end
`ifdef SINGLE_STEP_EN
            WAIT_STEP: begin
                if (Step) state_d = T0;
            end
`endif
            default: state_d = RESET_ST;
        endcase
    end

endmodule
